// File: rtl/pc_sequencer.sv
// pc_sequencer: PC, NVZ flags and retired-instruction counter with a RUN/HALTED FSM.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic        br_reg_take,
  input  logic [15:0] br_target,
  input  logic        stall,
  input  logic        hlt,
  input  logic [2:0]  flag_we,
  input  logic [2:0]  alu_flags,
  output logic [15:0] pc,
  output logic [2:0]  flags,
  output logic        halted,
  output logic [15:0] instr_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, cnt_q, cnt_d;
  logic [2:0]  flags_q, flags_d;
  logic        halted_q, halted_d, adv, exec;
  always_comb begin
    adv      = (state_q == RUN) && !stall;
    exec     = adv && !hlt;
    pc_d     = exec ? (br_reg_take ? br_target : next_pc) : pc_q;
    flags_d  = exec ? (flag_we & alu_flags) | (~flag_we & flags_q) : flags_q;
    cnt_d    = adv ? cnt_q + 16'd1 : cnt_q;
    state_d  = (adv && hlt) ? HALTED : state_q;
    halted_d = (state_d == HALTED);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      flags_q  <= 3'b000;
      cnt_q    <= 16'h0000;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end
  assign pc          = pc_q;
  assign flags       = flags_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port next_pc, input, 16, the sequential or branch-resolved next PC from the branch/PC-control logic.
REQ-005 SHALL have port br_reg_take, input, 1, meaning a resolved, taken register-indirect branch (BR) this cycle.
REQ-006 SHALL have port br_target, input, 16, the register-sourced BR target address.
REQ-007 SHALL have port stall, input, 1, meaning hold all architectural state this cycle.
REQ-008 SHALL have port hlt, input, 1, meaning the current instruction is HLT.
REQ-009 SHALL have port flag_we, input, 3, the per-flag write enables in bit order {N,V,Z}.
REQ-010 SHALL have port alu_flags, input, 3, the ALU-computed flags in bit order {N,V,Z}.
REQ-011 SHALL have port pc, output, 16, the current PC, fed back as the branch logic's PC input.
REQ-012 SHALL have port flags, output, 3, the registered flags {N,V,Z}, with flags[2]=N, flags[1]=V and flags[0]=Z.
REQ-013 SHALL have port halted, output, 1, high while in state HALTED.
REQ-014 SHALL have port instr_count, output, 16, the count of retired instructions.

Function
REQ-015 SHALL implement a two-state FSM: RUN and HALTED.
REQ-016 A cycle SHALL be an "advance" when the state is RUN and stall=0.
REQ-017 On an advance with hlt=0 and br_reg_take=1, pc SHALL load br_target at the next edge.
REQ-018 On an advance with hlt=0 and br_reg_take=0, pc SHALL load next_pc at the next edge.
REQ-019 On an advance with hlt=0, each flags bit i SHALL load alu_flags[i] when flag_we[i]=1 and SHALL hold otherwise.
REQ-020 On an advance with hlt=1, pc and flags SHALL hold, the FSM SHALL go to HALTED, and br_reg_take and flag_we SHALL be ignored.
REQ-021 Priority SHALL be rst_n=0 first, then HALTED, then stall, then hlt, then br_reg_take, then next_pc.
REQ-022 When stall=1 in RUN, pc, flags, instr_count and state SHALL hold, even if hlt=1 in the same cycle.
REQ-023 In HALTED, pc, flags and instr_count SHALL hold indefinitely, all non-reset inputs SHALL be ignored, and only reset SHALL exit the state.
REQ-024 instr_count SHALL increment by 1 on every advance, including the HLT advance, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 PC values SHALL be used as given, with no alignment checking and no saturation; an odd or wrapped address passes through unchanged.
REQ-026 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.
REQ-027 halted SHALL be asserted in the cycle after the HLT advance edge.

Reset
REQ-028 While rst_n=0 at a rising edge, the next state SHALL be pc=RESET_PC, flags=3'b000, instr_count=0, state=RUN and halted=0.
REQ-029 Reset asserted mid-operation, including while stalled or in HALTED, SHALL override all other inputs in that same edge.
REQ-030 Reset SHALL have no asynchronous effect; outputs SHALL change only on clk edges.

Verification
REQ-031 Bench SHALL cover sequential run: after reset, drive next_pc=pc+2 for 4 advances -> pc=0x0008, instr_count=4.
REQ-032 Bench SHALL cover BR priority: pc=0x0010, br_reg_take=1, br_target=0x1234, next_pc=0x0012 -> pc=0x1234 next cycle.
REQ-033 Bench SHALL cover flag masking: flags=3'b000, flag_we=3'b001, alu_flags=3'b111 -> flags=3'b001; then flag_we=3'b110, alu_flags=3'b100 -> flags=3'b101.
REQ-034 Bench SHALL cover stall with HLT: stall=1 and hlt=1 for 3 cycles -> pc, flags, instr_count unchanged and halted=0; release stall with hlt=1 -> halted=1 next cycle, pc unchanged, instr_count+1.
REQ-035 Bench SHALL cover halted hold and reset exit: in HALTED, toggle all inputs for 10 cycles -> no output change; then rst_n=0 for 1 edge -> pc=0x0000, flags=0, instr_count=0, halted=0.
REQ-036 Bench SHALL cover counter wrap: preload instr_count to 0xFFFF via advances, one more advance -> instr_count=0x0000, pc updated normally.
